// File: rtl/matrix_exec_core_pkg.sv
// Shared definitions for the matrix execution core: opcodes, FSM encoding,
// default geometry and element-access helpers.
package matrix_exec_core_pkg;

  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultEw    = 16;

  localparam logic [4:0] OpNop       = 5'h00;
  localparam logic [4:0] OpAdd       = 5'h01;
  localparam logic [4:0] OpSub       = 5'h02;
  localparam logic [4:0] OpMult      = 5'h03;
  localparam logic [4:0] OpScale     = 5'h04;
  localparam logic [4:0] OpTranspose = 5'h05;
  localparam logic [4:0] OpHalt      = 5'h1F;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWrite,
    StHalt
  } state_e;

  // Bit offset of element r,c in a row-major 4x4 matrix of ew-bit elements.
  function automatic int unsigned elem_offset(int unsigned r, int unsigned c, int unsigned ew);
    return ew * (4 * r + c);
  endfunction

  function automatic logic [DefaultEw-1:0] mat_elem(logic [16*DefaultEw-1:0] m,
                                                    int unsigned r, int unsigned c);
    return m[elem_offset(r, c, DefaultEw) +: DefaultEw];
  endfunction

  // Opcodes that go through READ/EXEC and write a result back.
  function automatic logic is_exec_op(logic [4:0] op);
    return (op >= OpAdd) && (op <= OpTranspose);
  endfunction

endpackage

// File: rtl/matrix_addsub_unit.sv
// Element-wise 4x4 add/subtract with a result register; each element wraps
// independently, with no carry between elements.
module matrix_addsub_unit
  import matrix_exec_core_pkg::*;
#(
  parameter int unsigned EW = DefaultEw
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            capture_i,
  input  logic            sub_i,
  input  logic [16*EW-1:0] a_i,
  input  logic [16*EW-1:0] b_i,
  output logic [16*EW-1:0] result_o
);

  logic [16*EW-1:0] result_d;
  logic [16*EW-1:0] result_q;

  always_comb begin
    result_d = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        result_d[elem_offset(r, c, EW) +: EW] = sub_i ?
            a_i[elem_offset(r, c, EW) +: EW] - b_i[elem_offset(r, c, EW) +: EW] :
            a_i[elem_offset(r, c, EW) +: EW] + b_i[elem_offset(r, c, EW) +: EW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (capture_i) begin
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/matrix_exec_core.sv
// Matrix CPU execution core: accepts one decoded instruction at a time, reads
// two matrices from local memory, runs ADD/SUB or dispatches to external units.
module matrix_exec_core
  import matrix_exec_core_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned EW    = DefaultEw
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [4:0]      instr,
  input  logic [6:0]      dest,
  input  logic [6:0]      src1,
  input  logic [6:0]      src2,
  output logic            busy,
  output logic            done,
  output logic            halted,
  input  logic            load_en,
  input  logic [6:0]      load_addr,
  input  logic [16*EW-1:0] load_data,
  input  logic [6:0]      dbg_addr,
  output logic [16*EW-1:0] dbg_data,
  output logic [16*EW-1:0] src1_data,
  output logic [16*EW-1:0] src2_data,
  output logic            enable_mult,
  output logic            enable_scale,
  output logic            enable_transpose,
  input  logic [16*EW-1:0] ext_result
);

  localparam int unsigned MW = 16 * EW;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(logic [6:0] a);
    return 32'(a) < DEPTH;
  endfunction

  state_e     state_q, state_d;
  logic       accept;
  logic [4:0] op_q;
  logic [6:0] dest_q, src1_addr_q, src2_addr_q;

  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] src1_data_q, src2_data_q;
  logic [MW-1:0] rd1, rd2;
  logic [MW-1:0] addsub_result;

  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [MW-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          accept = 1'b1;
          if (instr == OpHalt)         state_d = StHalt;
          else if (is_exec_op(instr))  state_d = StRead;
          else                         state_d = StWrite;  // NOP: straight to done
        end
      end
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      dest_q      <= '0;
      src1_addr_q <= '0;
      src2_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q        <= instr;
        dest_q      <= dest;
        src1_addr_q <= src1;
        src2_addr_q <= src2;
      end
    end
  end

  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StWrite);
  assign halted           = (state_q == StHalt);
  assign enable_mult      = (state_q == StExec) && (op_q == OpMult);
  assign enable_scale     = (state_q == StExec) && (op_q == OpScale);
  assign enable_transpose = (state_q == StExec) && (op_q == OpTranspose);

  assign rd1      = in_range(src1_addr_q) ? mem_q[src1_addr_q[AW-1:0]] : '0;
  assign rd2      = in_range(src2_addr_q) ? mem_q[src2_addr_q[AW-1:0]] : '0;
  assign dbg_data = in_range(dbg_addr) ? mem_q[dbg_addr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src1_data_q <= '0;
      src2_data_q <= '0;
    end else if (state_q == StRead) begin
      src1_data_q <= rd1;
      src2_data_q <= rd2;
    end
  end

  assign src1_data = src1_data_q;
  assign src2_data = src2_data_q;

  matrix_addsub_unit #(
    .EW(EW)
  ) u_addsub (
    .clk_i    (clk),
    .rst_ni   (reset),
    .capture_i((state_q == StExec) && ((op_q == OpAdd) || (op_q == OpSub))),
    .sub_i    (op_q == OpSub),
    .a_i      (src1_data_q),
    .b_i      (src2_data_q),
    .result_o (addsub_result)
  );

  // Pipeline write-back and preload never collide: preload needs busy=0.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if ((state_q == StWrite) && is_exec_op(op_q)) begin
      wr_en   = 1'b1;
      wr_addr = dest_q;
      wr_data = ((op_q == OpAdd) || (op_q == OpSub)) ? addsub_result : ext_result;
    end else if (load_en && !busy) begin
      wr_en   = 1'b1;
      wr_addr = load_addr;
      wr_data = load_data;
    end
    if (!in_range(wr_addr)) wr_en = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_exec_core.sv
// Directed self-checking bench for matrix_exec_core.
module tb_matrix_exec_core;
  import matrix_exec_core_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic [4:0]   instr;
  logic [6:0]   dest, src1, src2;
  logic         busy, done, halted;
  logic         load_en;
  logic [6:0]   load_addr;
  logic [255:0] load_data;
  logic [6:0]   dbg_addr;
  logic [255:0] dbg_data, src1_data, src2_data;
  logic         enable_mult, enable_scale, enable_transpose;
  logic [255:0] ext_result;

  int n_cmp = 0;
  int n_fail = 0;

  logic         busy_log [8];
  logic         done_log [8];
  logic         em_log [8];
  logic         es_log [8];
  logic         et_log [8];
  logic [255:0] s1_log [8];
  logic [255:0] s2_log [8];

  matrix_exec_core dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .dest            (dest),
    .src1            (src1),
    .src2            (src2),
    .busy            (busy),
    .done            (done),
    .halted          (halted),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .src1_data       (src1_data),
    .src2_data       (src2_data),
    .enable_mult     (enable_mult),
    .enable_scale    (enable_scale),
    .enable_transpose(enable_transpose),
    .ext_result      (ext_result)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic rd(input logic [6:0] a, output logic [255:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic load(input logic [6:0] a, input logic [255:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Offers one instruction for a single cycle, then logs outputs #1 after each edge.
  task automatic issue(input logic [4:0] op, input logic [6:0] d, input logic [6:0] s1,
                       input logic [6:0] s2, input int ncyc);
    @(negedge clk);
    instr_valid = 1'b1; instr = op; dest = d; src1 = s1; src2 = s2;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 0) instr_valid = 1'b0;
      busy_log[k] = busy; done_log[k] = done;
      em_log[k] = enable_mult; es_log[k] = enable_scale; et_log[k] = enable_transpose;
      s1_log[k] = src1_data; s2_log[k] = src2_data;
    end
  endtask

  task automatic test_reset();
    logic [255:0] v;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (src1_data !== '0) begin n_fail++; $display("FAIL reset_src1: got %h want 0", src1_data); end
    for (int a = 0; a < 16; a++) begin
      rd(7'(a), v);
      n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL reset_mem%0d: got %h want 0", a, v); end
    end
  endtask

  task automatic test_add();
    logic [255:0] v;
    load(0, fill(16'h0001));
    load(1, fill(16'h0002));
    issue(OpAdd, 2, 0, 1, 4);
    n_cmp++; if ({busy_log[0], busy_log[1], busy_log[2], busy_log[3]} !== 4'b1110) begin
      n_fail++; $display("FAIL add_busy: got %b%b%b%b want 1110",
                         busy_log[0], busy_log[1], busy_log[2], busy_log[3]); end
    n_cmp++; if ({done_log[0], done_log[1], done_log[2], done_log[3]} !== 4'b0010) begin
      n_fail++; $display("FAIL add_done: got %b%b%b%b want 0010",
                         done_log[0], done_log[1], done_log[2], done_log[3]); end
    rd(2, v);
    n_cmp++; if (v !== fill(16'h0003)) begin n_fail++; $display("FAIL add_mem2: got %h want %h", v, fill(16'h0003)); end
  endtask

  task automatic test_sub_wrap();
    logic [255:0] v, a6;
    issue(OpSub, 3, 0, 1, 4);
    rd(3, v);
    n_cmp++; if (v !== fill(16'hFFFF)) begin n_fail++; $display("FAIL sub_wrap: got %h want %h", v, fill(16'hFFFF)); end
    a6 = fill(16'h0010);
    a6[15:0] = 16'hFFFF;
    load(6, a6);
    load(7, fill(16'h0002));
    issue(OpAdd, 8, 6, 7, 4);
    rd(8, v);
    n_cmp++; if (mat_elem(v, 0, 0) !== 16'h0001) begin n_fail++; $display("FAIL add_wrap_e00: got %h want 0001", mat_elem(v, 0, 0)); end
    n_cmp++; if (mat_elem(v, 0, 1) !== 16'h0012) begin n_fail++; $display("FAIL add_wrap_e01: got %h want 0012", mat_elem(v, 0, 1)); end
    n_cmp++; if (mat_elem(v, 3, 3) !== 16'h0012) begin n_fail++; $display("FAIL add_wrap_e33: got %h want 0012", mat_elem(v, 3, 3)); end
  endtask

  task automatic test_ext_units();
    logic [255:0] v;
    ext_result = fill(16'hA5A5);
    issue(OpMult, 4, 0, 1, 4);
    n_cmp++; if ({em_log[0], em_log[1], em_log[2], em_log[3]} !== 4'b0100) begin
      n_fail++; $display("FAIL mult_enable: got %b%b%b%b want 0100", em_log[0], em_log[1], em_log[2], em_log[3]); end
    n_cmp++; if ({es_log[1], et_log[1]} !== 2'b00) begin
      n_fail++; $display("FAIL mult_other_en: got %b%b want 00", es_log[1], et_log[1]); end
    n_cmp++; if (s1_log[1] !== fill(16'h0001)) begin n_fail++; $display("FAIL mult_src1: got %h want %h", s1_log[1], fill(16'h0001)); end
    n_cmp++; if (s2_log[1] !== fill(16'h0002)) begin n_fail++; $display("FAIL mult_src2: got %h want %h", s2_log[1], fill(16'h0002)); end
    rd(4, v);
    n_cmp++; if (v !== fill(16'hA5A5)) begin n_fail++; $display("FAIL mult_mem4: got %h want %h", v, fill(16'hA5A5)); end
    ext_result = fill(16'h1234);
    issue(OpScale, 15, 0, 1, 4);
    n_cmp++; if ({em_log[1], es_log[1], et_log[1]} !== 3'b010) begin
      n_fail++; $display("FAIL scale_enable: got %b%b%b want 010", em_log[1], es_log[1], et_log[1]); end
    rd(15, v);
    n_cmp++; if (v !== fill(16'h1234)) begin n_fail++; $display("FAIL scale_mem15: got %h want %h", v, fill(16'h1234)); end
    // dest 20 is out of range and must not alias onto entry 4
    ext_result = fill(16'h5A5A);
    issue(OpTranspose, 20, 0, 1, 4);
    n_cmp++; if ({em_log[1], es_log[1], et_log[1]} !== 3'b001) begin
      n_fail++; $display("FAIL transpose_enable: got %b%b%b want 001", em_log[1], es_log[1], et_log[1]); end
    rd(4, v);
    n_cmp++; if (v !== fill(16'hA5A5)) begin n_fail++; $display("FAIL oob_dest_drop: got %h want %h", v, fill(16'hA5A5)); end
  endtask

  task automatic test_boundaries();
    logic [255:0] v;
    issue(OpAdd, 12, 0, 17, 4);
    rd(12, v);
    n_cmp++; if (v !== fill(16'h0001)) begin n_fail++; $display("FAIL oob_src_zero: got %h want %h", v, fill(16'h0001)); end
    load(13, fill(16'h0005));
    issue(OpAdd, 13, 13, 13, 4);
    rd(13, v);
    n_cmp++; if (v !== fill(16'h000A)) begin n_fail++; $display("FAIL dest_eq_src: got %h want %h", v, fill(16'h000A)); end
    load(16, fill(16'h7777));
    rd(16, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL oob_load_read: got %h want 0", v); end
    rd(0, v);
    n_cmp++; if (v !== fill(16'h0001)) begin n_fail++; $display("FAIL oob_load_alias: got %h want %h", v, fill(16'h0001)); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] v;
    @(negedge clk);
    instr_valid = 1'b1; instr = OpAdd; dest = 9; src1 = 0; src2 = 0;
    @(posedge clk); #1;
    instr = OpSub; dest = 10; src1 = 1; src2 = 0;
    load_en = 1'b1; load_addr = 11; load_data = fill(16'hBEEF);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    instr_valid = 1'b0; load_en = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_queue: got busy=%b want 0", busy); end
    rd(9, v);
    n_cmp++; if (v !== fill(16'h0002)) begin n_fail++; $display("FAIL b2b_first: got %h want %h", v, fill(16'h0002)); end
    rd(10, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL b2b_second_ignored: got %h want 0", v); end
    rd(11, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL load_while_busy: got %h want 0", v); end
  endtask

  task automatic test_nop();
    logic [255:0] v;
    ext_result = fill(16'hCCCC);
    issue(OpNop, 14, 0, 1, 2);
    n_cmp++; if ({done_log[0], done_log[1]} !== 2'b10) begin
      n_fail++; $display("FAIL nop_done: got %b%b want 10", done_log[0], done_log[1]); end
    n_cmp++; if (busy_log[1] !== 1'b0) begin n_fail++; $display("FAIL nop_idle: got %b want 0", busy_log[1]); end
    issue(5'h07, 14, 0, 1, 2);
    n_cmp++; if ({done_log[0], done_log[1]} !== 2'b10) begin
      n_fail++; $display("FAIL badop_done: got %b%b want 10", done_log[0], done_log[1]); end
    rd(14, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL nop_no_write: got %h want 0", v); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] v;
    issue(OpAdd, 5, 0, 1, 2);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (src1_data !== '0) begin n_fail++; $display("FAIL rstmid_src1: got %h want 0", src1_data); end
    rd(0, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL rstmid_mem0: got %h want 0", v); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got busy=%b done=%b want 0 0", busy, done); end
    rd(5, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL rstmid_mem5: got %h want 0", v); end
  endtask

  task automatic test_halt();
    logic [255:0] v;
    load(0, fill(16'h0001));
    issue(OpHalt, 0, 0, 0, 1);
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_flags: got halted=%b busy=%b want 1 1", halted, busy); end
    load(0, fill(16'h0007));
    issue(OpAdd, 2, 0, 0, 4);
    n_cmp++; if ({done_log[0], done_log[1], done_log[2], done_log[3]} !== 4'b0000) begin
      n_fail++; $display("FAIL halt_no_done: got %b%b%b%b want 0000",
                         done_log[0], done_log[1], done_log[2], done_log[3]); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", halted); end
    rd(2, v);
    n_cmp++; if (v !== '0) begin n_fail++; $display("FAIL halt_no_write: got %h want 0", v); end
    rd(0, v);
    n_cmp++; if (v !== fill(16'h0001)) begin n_fail++; $display("FAIL halt_no_load: got %h want %h", v, fill(16'h0001)); end
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0; dest = '0; src1 = '0; src2 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0; ext_result = '0;
    #2;
    test_reset();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub_wrap();
    test_ext_units();
    test_boundaries();
    test_back_to_back();
    test_nop();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
